// File: rtl/serial_alu.sv
// serial_alu: multi-cycle ALU that processes SLICE bits per cycle, least-significant slice first
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);
    localparam int NS = WIDTH / SLICE;
    localparam int CW = NS > 1 ? $clog2(NS) : 1;
    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic [2:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, zero_q, zero_d, ill_q, ill_d;
    logic inv, bad, last, lt;
    logic [SLICE-1:0] sa, sb, sr;
    logic [SLICE:0] sum;
    always_comb begin
        inv = op_q == 3'b001 || op_q == 3'b101;
        bad = op_q == 3'b100 || op_q[2:1] == 2'b11;
        sa = a_q[SLICE-1:0];
        sb = b_q[SLICE-1:0] ^ {SLICE{inv}};
        sum = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry_q};
        sr = op_q == 3'b010 ? sa & sb : op_q == 3'b011 ? sa | sb : sum[SLICE-1:0];
        last = cnt_q == CW'(NS - 1);
        // signed less-than from the top slice: sign of difference corrected by overflow
        lt = sum[SLICE-1] ^ ((sa[SLICE-1] == sb[SLICE-1]) && (sum[SLICE-1] != sa[SLICE-1]));
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        op_d = op_q;
        cnt_d = cnt_q;
        carry_d = carry_q;
        res_d = res_q;
        zero_d = zero_q;
        ill_d = ill_q;
        case (state_q)
            IDLE: if (start) begin
                a_d = SrcA;
                b_d = SrcB;
                op_d = ALUControl;
                acc_d = '0;
                cnt_d = '0;
                carry_d = ALUControl == 3'b001 || ALUControl == 3'b101;
                state_d = EXEC;
            end
            EXEC: begin
                a_d = a_q >> SLICE;
                b_d = b_q >> SLICE;
                acc_d = (acc_q >> SLICE) | (WIDTH'(sr) << (WIDTH - SLICE));
                carry_d = sum[SLICE];
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    res_d = bad ? '0 : op_q == 3'b101 ? WIDTH'(lt) : acc_d;
                    zero_d = res_d == '0;
                    ill_d = bad;
                    state_d = FIN;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            op_q <= '0;
            cnt_q <= '0;
            carry_q <= 1'b0;
            res_q <= '0;
            zero_q <= 1'b1;
            ill_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            carry_q <= carry_d;
            res_q <= res_d;
            zero_q <= zero_d;
            ill_q <= ill_d;
        end
    end
    assign busy = state_q == EXEC;
    assign done = state_q == FIN;
    assign ALUResult = res_q;
    assign Zero = zero_q;
    assign illegal = ill_q;
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed scoreboard bench for serial_alu at WIDTH=32, SLICE=8
module tb_serial_alu;
    logic clk = 1'b0;
    logic reset, start, busy, done, Zero, illegal;
    logic [2:0] ALUControl;
    logic [31:0] SrcA, SrcB, ALUResult;
    int passed = 0, total = 0;
    logic [33:0] sb_q[$];
    always #5 clk = ~clk;
    serial_alu #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    // g=1: second start in cycle 2; g=2: start held during the done cycle
    task automatic run(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic il, input int g);
        logic [33:0] e;
        int n;
        @(negedge clk);
        ALUControl = c; SrcA = a; SrcB = b; start = 1'b1;
        sb_q.push_back({r, z, il});
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            chk("busy_exec", 32'(busy), 32'd1);
            SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom);
            start = (g == 1 && n == 2);
            @(negedge clk);
            n++;
        end
        chk("latency", n, 32'd5);
        chk("done", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd0);
        e = sb_q.pop_front();
        chk("result", ALUResult, e[33:2]);
        chk("zero", 32'(Zero), 32'(e[1]));
        chk("illegal", 32'(illegal), 32'(e[0]));
        start = (g == 2);
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("hold", ALUResult, e[33:2]);
    endtask
    initial begin
        int hits;
        reset = 1'b1; start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        run(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 0);
        run(3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 0);
        run(3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 0);
        run(3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        run(3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0);
        run(3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 0);
        run(3'b101, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 0);
        run(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 0);
        run(3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 0);
        run(3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 0);
        run(3'b100, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 0);
        run(3'b110, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 0);
        run(3'b001, 32'h00000009, 32'h00000002, 32'h00000007, 1'b0, 1'b0, 2);
        run(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1);
        @(negedge clk);
        ALUControl = 3'b000; SrcA = 32'h00000011; SrcB = 32'h00000022; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", ALUResult, 32'd0);
        chk("abort_zero", 32'(Zero), 32'd1);
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) hits++;
        end
        chk("abort_no_done", hits, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
